// File: rtl/sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_req_arbiter
// Purpose  : Two-client request stage in front of the 16-bit async SRAM
//            controller. Port A (video line fetch, read-only) and port B (CPU
//            read/write) share one controller. Exactly one single-cycle
//            request is issued at a time, address/write data are held for the
//            whole access, and read data is routed back to the owning port.
//            Port A wins ties until it has taken MAX_A_BURST grants in a row
//            while B was waiting.
// Options  : `define SRAM_ARB_TIMEOUT_EN builds a WAIT-state watchdog that
//            aborts after TIMEOUT_CYCLES, returns 16'hDEAD and sets the sticky
//            timeout_err flag.
// Revision : 1.0 - initial release
// ============================================================================
module sram_req_arbiter #(
    parameter int MAX_A_BURST    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic [16:0] a_addr,
    output logic        a_ack,
    output logic [15:0] a_rdata,
    output logic        a_rvalid,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [16:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_ack,
    output logic [15:0] b_rdata,
    output logic        b_rvalid,
    output logic        b_wdone,
    output logic        mem_read_req,
    output logic        mem_write_req,
    output logic [16:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [3:0]  c_MAX_BURST = 4'(MAX_A_BURST);
    localparam logic [15:0] c_TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_grant_a;
    logic        w_grant_b;
    logic        w_done;
    logic        w_to_hit;
    logic        w_finish;
    logic [15:0] w_rdata_in;

    logic        r_owner_b;
    logic        r_op_write;
    logic [3:0]  r_burst;
    logic [16:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_a_rdata;
    logic [15:0] r_b_rdata;
    logic        r_a_ack;
    logic        r_b_ack;
    logic        r_rd_req;
    logic        r_wr_req;
    logic        r_a_rvalid;
    logic        r_b_rvalid;
    logic        r_b_wdone;
    logic        r_busy;

    // Grant decision and next-state selection; requests are only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_a   = 1'b0;
        w_grant_b   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (a_req && (!b_req || (r_burst != c_MAX_BURST))) begin
                    w_grant_a = 1'b1;
                end else if (b_req) begin
                    w_grant_b = 1'b1;
                end
                if (a_req || b_req) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_to_hit) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // An access ends either on mem_ready or on a watchdog abort.
    assign w_finish = w_done | w_to_hit;

`ifdef SRAM_ARB_TIMEOUT_EN
    logic [15:0] r_to_cnt;
    logic        r_to_err;

    assign w_to_hit    = (r_state == S_WAIT) && !mem_ready && (r_to_cnt == c_TO_LAST);
    assign w_rdata_in  = w_done ? mem_rdata : 16'hDEAD;
    assign timeout_err = r_to_err;

    // Watchdog: counts cycles spent in WAIT, error flag is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= 16'd0;
            r_to_err <= 1'b0;
        end else begin
            if (r_state == S_WAIT) begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end else begin
                r_to_cnt <= 16'd0;
            end
            if (w_to_hit) begin
                r_to_err <= 1'b1;
            end
        end
    end
`else
    logic w_unused_timeout;

    assign w_to_hit         = 1'b0;
    assign w_rdata_in       = mem_rdata;
    assign timeout_err      = 1'b0;
    assign w_unused_timeout = ^c_TO_LAST;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered handshake pulses: ack/request in ISSUE, response in the IDLE cycle after completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_ack    <= 1'b0;
            r_b_ack    <= 1'b0;
            r_rd_req   <= 1'b0;
            r_wr_req   <= 1'b0;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_b_wdone  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_a_ack    <= w_grant_a;
            r_b_ack    <= w_grant_b;
            r_rd_req   <= w_grant_a | (w_grant_b & ~b_we);
            r_wr_req   <= w_grant_b & b_we;
            r_a_rvalid <= w_finish & ~r_owner_b;
            r_b_rvalid <= w_finish & r_owner_b & ~r_op_write;
            r_b_wdone  <= w_finish & r_owner_b & r_op_write;
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

    // Access datapath: latch on grant, capture read data on completion, track A's burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner_b  <= 1'b0;
            r_op_write <= 1'b0;
            r_burst    <= 4'd0;
            r_addr     <= 17'd0;
            r_wdata    <= 16'd0;
            r_a_rdata  <= 16'd0;
            r_b_rdata  <= 16'd0;
        end else begin
            if (w_grant_a) begin
                r_addr     <= a_addr;
                r_owner_b  <= 1'b0;
                r_op_write <= 1'b0;
                if (b_req) begin
                    if (r_burst != c_MAX_BURST) begin
                        r_burst <= r_burst + 4'd1;
                    end
                end else begin
                    r_burst <= 4'd0;
                end
            end
            if (w_grant_b) begin
                r_addr     <= b_addr;
                r_wdata    <= b_wdata;
                r_owner_b  <= 1'b1;
                r_op_write <= b_we;
                r_burst    <= 4'd0;
            end
            if (w_finish && !r_owner_b) begin
                r_a_rdata <= w_rdata_in;
            end
            if (w_finish && r_owner_b && !r_op_write) begin
                r_b_rdata <= w_rdata_in;
            end
        end
    end

    assign a_ack         = r_a_ack;
    assign b_ack         = r_b_ack;
    assign mem_read_req  = r_rd_req;
    assign mem_write_req = r_wr_req;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign a_rdata       = r_a_rdata;
    assign b_rdata       = r_b_rdata;
    assign a_rvalid      = r_a_rvalid;
    assign b_rvalid      = r_b_rvalid;
    assign b_wdone       = r_b_wdone;
    assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_req_arbiter
// Purpose  : Self-checking bench for sram_req_arbiter: directed vector table,
//            arbitration / drop / reset / timeout sequences, and a randomized
//            two-client run checked by a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_req_arbiter;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, b_req, b_we;
    logic [16:0] a_addr, b_addr;
    logic [15:0] b_wdata;
    logic        a_ack, a_rvalid, b_ack, b_rvalid, b_wdone;
    logic [15:0] a_rdata, b_rdata;
    logic        mem_read_req, mem_write_req, mem_ready, busy, timeout_err;
    logic [16:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    int errs   = 0;
    int checks = 0;

    sram_req_arbiter #(.MAX_A_BURST(MAXB), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack),
        .b_rdata(b_rdata), .b_rvalid(b_rvalid), .b_wdone(b_wdone),
        .mem_read_req(mem_read_req), .mem_write_req(mem_write_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- SRAM + controller environment model ----------------
    logic [15:0] sram_mem [int];
    logic [15:0] ref_mem  [int];
    int unsigned lat      = 3;
    bit          lat_rand = 1'b0;
    bit          mem_mute = 1'b0;
    int          rst_gen  = 0;
    logic [16:0] m_ad;
    logic [15:0] m_wd;
    bit          m_wr;
    int          m_l, m_gen;

    function automatic logic [15:0] def_data(input logic [16:0] ad);
        return ad[15:0] ^ 16'h5A5A ^ {15'd0, ad[16]};
    endfunction

    function automatic logic [15:0] ref_rd(input logic [16:0] ad);
        return ref_mem.exists(int'(ad)) ? ref_mem[int'(ad)] : def_data(ad);
    endfunction

    initial forever begin
        @(negedge rst_n);
        rst_gen++;
    end

    // Answers each request with a one-cycle mem_ready 'lat' cycles after it.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 16'd0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && (mem_read_req || mem_write_req)) begin
                m_ad  = mem_addr;
                m_wr  = mem_write_req;
                m_wd  = mem_wdata;
                m_l   = lat_rand ? int'($urandom_range(1, 5)) : int'(lat);
                m_gen = rst_gen;
                if (m_wr) sram_mem[int'(m_ad)] = m_wd;
                repeat (m_l) @(posedge clk);
                #1;
                if (!mem_mute && m_gen == rst_gen && rst_n === 1'b1) begin
                    mem_ready = 1'b1;
                    mem_rdata = m_wr ? ~m_wd :
                                (sram_mem.exists(int'(m_ad)) ? sram_mem[int'(m_ad)] : def_data(m_ad));
                    @(posedge clk);
                    #1;
                    mem_ready = 1'b0;
                end
            end
        end
    end

    // ---------------- transaction-level reference monitor ----------------
    bit          mon_en = 1'b0;
    bit          m_out, m_outb, m_outw, m_idle_prev, m_rdy_prev, m_pa, m_pb, m_pbwe, m_pulse;
    logic [16:0] m_paa, m_pba, m_oaddr;
    logic [15:0] m_pbwd, m_owd;
    int          m_cnt, m_g;

    initial forever begin
        @(negedge clk);
        if (!mon_en) begin
            m_out = 0; m_rdy_prev = 0; m_cnt = 0; m_idle_prev = 1;
        end else begin
            m_pulse = m_rdy_prev;
            chk("mon_a_rvalid", a_rvalid, m_pulse && !m_outb);
            chk("mon_b_rvalid", b_rvalid, m_pulse && m_outb && !m_outw);
            chk("mon_b_wdone", b_wdone, m_pulse && m_outb && m_outw);
            if (m_pulse) begin
                if (!m_outb)      chk("mon_a_rdata", a_rdata, ref_rd(m_oaddr));
                else if (!m_outw) chk("mon_b_rdata", b_rdata, ref_rd(m_oaddr));
                else              ref_mem[int'(m_oaddr)] = m_owd;
                m_out = 0;
            end
            m_g = 0;
            if (m_idle_prev && (m_pa || m_pb))
                m_g = (m_pa && (!m_pb || m_cnt != MAXB)) ? 1 : 2;
            chk("mon_a_ack", a_ack, m_g == 1);
            chk("mon_b_ack", b_ack, m_g == 2);
            chk("mon_rd_req", mem_read_req, m_g == 1 || (m_g == 2 && !m_pbwe));
            chk("mon_wr_req", mem_write_req, m_g == 2 && m_pbwe);
            if (m_g != 0) begin
                m_oaddr = (m_g == 1) ? m_paa : m_pba;
                chk("mon_grant_addr", mem_addr, m_oaddr);
                if (m_g == 2 && m_pbwe) chk("mon_grant_wdata", mem_wdata, m_pbwd);
                m_out  = 1;
                m_outb = (m_g == 2);
                m_outw = (m_g == 2) && m_pbwe;
                m_owd  = m_pbwd;
                if (m_g == 1) m_cnt = m_pb ? ((m_cnt < MAXB) ? m_cnt + 1 : MAXB) : 0;
                else          m_cnt = 0;
            end else if (m_out) begin
                chk("mon_hold_addr", mem_addr, m_oaddr);
                if (m_outw) chk("mon_hold_wdata", mem_wdata, m_owd);
            end
            chk("mon_busy", busy, m_out);
            m_rdy_prev  = m_out && (m_g == 0) && mem_ready;
            m_idle_prev = !m_out;
        end
        m_pa = a_req; m_pb = b_req; m_paa = a_addr; m_pba = b_addr; m_pbwe = b_we; m_pbwd = b_wdata;
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          is_b;
        bit          we;
        logic [16:0] addr;
        logic [15:0] wdata;
        bit          pre;
        logic [15:0] pre_data;
        int          lat;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_a_ack"}, a_ack, 0);
        chk({tag, "_b_ack"}, b_ack, 0);
        chk({tag, "_a_rvalid"}, a_rvalid, 0);
        chk({tag, "_b_rvalid"}, b_rvalid, 0);
        chk({tag, "_b_wdone"}, b_wdone, 0);
        chk({tag, "_rd_req"}, mem_read_req, 0);
        chk({tag, "_wr_req"}, mem_write_req, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_a_rdata"}, a_rdata, 0);
        chk({tag, "_b_rdata"}, b_rdata, 0);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        bit seen, stable, wr;
        wr = v.is_b && v.we;
        if (v.pre) sram_mem[int'(v.addr)] = v.pre_data;
        lat = v.lat;
        tick();
        if (v.is_b) begin
            b_req = 1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
        end else begin
            a_req = 1; a_addr = v.addr;
        end
        tick();
        chk({tag, "_ack"}, v.is_b ? b_ack : a_ack, 1);
        chk({tag, "_other_ack"}, v.is_b ? a_ack : b_ack, 0);
        chk({tag, "_rd_req"}, mem_read_req, !wr);
        chk({tag, "_wr_req"}, mem_write_req, wr);
        chk({tag, "_addr"}, mem_addr, v.addr);
        if (wr) chk({tag, "_wdata"}, mem_wdata, v.wdata);
        a_req = 0; b_req = 0;
        n = 0; seen = 0; stable = 1;
        while (!seen && n < 60) begin
            tick();
            n++;
            if (a_rvalid || b_rvalid || b_wdone) seen = 1;
            if (mem_read_req || mem_write_req || mem_addr !== v.addr || (wr && mem_wdata !== v.wdata))
                stable = 0;
        end
        chk({tag, "_resp_seen"}, seen, 1);
        chk({tag, "_held_stable"}, stable, 1);
        chk({tag, "_latency"}, n, v.lat + 1);
        chk({tag, "_a_rvalid"}, a_rvalid, !v.is_b);
        chk({tag, "_b_rvalid"}, b_rvalid, v.is_b && !v.we);
        chk({tag, "_b_wdone"}, b_wdone, wr);
        if (!wr) chk({tag, "_rdata"}, v.is_b ? b_rdata : a_rdata, v.exp_data);
        tick();
        chk({tag, "_pulse_1cyc"}, {a_rvalid, b_rvalid, b_wdone}, 0);
    endtask

    task automatic wait_quiet(input string tag);
        int k = 0;
        while ((busy || a_rvalid || b_rvalid || b_wdone) && k < 100) begin
            tick();
            k++;
        end
        chk({tag, "_drained"}, busy, 0);
        tick();
    endtask

    // ---------------- random clients ----------------
    task automatic drive_a(input int n);
        int  k;
        bit  got, drop;
        int  hold;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            a_addr = {1'($urandom_range(0, 1)), 13'd0, 3'($urandom_range(0, 7))};
            a_req  = 1;
            drop   = ($urandom_range(0, 7) == 0);
            hold   = int'($urandom_range(1, 2));
            got = 0; k = 0;
            while (!got && k < 300) begin
                tick();
                k++;
                if (a_ack) got = 1;
                else if (drop && k >= hold) break;
            end
            a_req = 0;
            if (drop && !got) continue;
            chk("rand_a_ack_seen", got, 1);
            got = 0; k = 0;
            while (!got && k < 300) begin
                tick();
                k++;
                if (a_rvalid) got = 1;
            end
            chk("rand_a_resp_seen", got, 1);
        end
    endtask

    task automatic drive_b(input int n);
        int  k;
        bit  got, drop;
        int  hold;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            b_addr  = {1'($urandom_range(0, 1)), 13'd0, 3'($urandom_range(0, 7))};
            b_we    = 1'($urandom_range(0, 1));
            b_wdata = 16'($urandom);
            b_req   = 1;
            drop    = ($urandom_range(0, 7) == 0);
            hold    = int'($urandom_range(1, 2));
            got = 0; k = 0;
            while (!got && k < 300) begin
                tick();
                k++;
                if (b_ack) got = 1;
                else if (drop && k >= hold) break;
            end
            b_req = 0;
            if (drop && !got) continue;
            chk("rand_b_ack_seen", got, 1);
            got = 0; k = 0;
            while (!got && k < 300) begin
                tick();
                k++;
                if (b_rvalid || b_wdone) got = 1;
            end
            chk("rand_b_resp_seen", got, 1);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        string exp_seq;
        int    grants, cyc, k;
        bit    seen_a, seen_b;

        rst_n = 1; a_req = 0; b_req = 0; b_we = 0;
        a_addr = 0; b_addr = 0; b_wdata = 0;
        #1 rst_n = 0;
        #2 check_zero_outputs("reset");
        tick();
        tick();
        rst_n = 1;

        vecs[0] = '{0, 0, 17'h00123, 16'h0000, 1, 16'hBEEF, 5, 16'hBEEF};
        vecs[1] = '{1, 1, 17'h1FFFF, 16'hA5A5, 0, 16'h0000, 3, 16'h0000};
        vecs[2] = '{1, 0, 17'h1FFFF, 16'h0000, 0, 16'h0000, 2, 16'hA5A5};
        vecs[3] = '{0, 0, 17'h00000, 16'h0000, 1, 16'h1234, 1, 16'h1234};
        vecs[4] = '{1, 0, 17'h0ABCD, 16'h0000, 1, 16'h0F0F, 4, 16'h0F0F};
        vecs[5] = '{1, 1, 17'h00000, 16'hFFFF, 0, 16'h0000, 1, 16'h0000};
        vecs[6] = '{0, 0, 17'h00000, 16'h0000, 0, 16'h0000, 3, 16'hFFFF};
        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Both ports held: A gets MAXB grants, then B once, repeating.
        sram_mem[17'h00010] = 16'h1111;
        sram_mem[17'h00020] = 16'h2222;
        lat = 2;
        exp_seq = "AAAABAAAAB";
        tick();
        a_req = 1; a_addr = 17'h00010;
        b_req = 1; b_we = 0; b_addr = 17'h00020;
        grants = 0; cyc = 0;
        while (grants < 10 && cyc < 300) begin
            tick();
            cyc++;
            if (b_rvalid) begin
                chk("burst_a_rdata_hold", a_rdata, 16'h1111);
                chk("burst_b_rdata", b_rdata, 16'h2222);
            end
            if (a_ack || b_ack) begin
                chk($sformatf("burst_grant%0d", grants), a_ack ? 32'h41 : 32'h42, 32'(exp_seq[grants]));
                grants++;
                if (grants == 10) begin a_req = 0; b_req = 0; end
            end
        end
        chk("burst_grant_count", grants, 10);
        wait_quiet("burst");

        // B request withdrawn while A is in flight: never granted.
        lat = 6;
        a_req = 1; a_addr = 17'h00030;
        k = 0;
        while (!a_ack && k < 20) begin tick(); k++; end
        chk("drop_a_ack", a_ack, 1);
        a_req = 0;
        tick();
        b_req = 1; b_we = 0; b_addr = 17'h00040;
        tick();
        tick();
        b_req = 0;
        seen_a = 0; seen_b = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a_rvalid) seen_a = 1;
            if (b_ack || b_rvalid || b_wdone || mem_write_req) seen_b = 1;
        end
        chk("drop_a_done", seen_a, 1);
        chk("drop_no_b_activity", seen_b, 0);

        // Reset in the middle of a B read.
        lat = 10;
        sram_mem[17'h00050] = 16'h5555;
        b_req = 1; b_we = 0; b_addr = 17'h00050;
        k = 0;
        while (!b_ack && k < 20) begin tick(); k++; end
        chk("rstwait_b_ack", b_ack, 1);
        b_req = 0;
        tick();
        tick();
        #2 rst_n = 0;
        #1 check_zero_outputs("rstwait");
        tick();
        tick();
        rst_n = 1;
        seen_b = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (b_rvalid || a_rvalid || b_wdone) seen_b = 1;
        end
        chk("rstwait_no_resp", seen_b, 0);
        run_vec('{0, 0, 17'h00077, 16'h0000, 1, 16'h7777, 2, 16'h7777}, "post_rst");

`ifdef SRAM_ARB_TIMEOUT_EN
        // Memory never answers: watchdog returns DEAD and latches the error.
        mem_mute = 1; lat = 1;
        a_req = 1; a_addr = 17'h00005;
        k = 0;
        while (!a_ack && k < 20) begin tick(); k++; end
        chk("to_a_ack", a_ack, 1);
        a_req = 0;
        k = 0;
        while (!a_rvalid && k < 40) begin tick(); k++; end
        chk("to_a_rvalid", a_rvalid, 1);
        chk("to_a_rdata", a_rdata, 16'hDEAD);
        chk("to_err_set", timeout_err, 1);
        repeat (5) tick();
        chk("to_err_sticky", timeout_err, 1);
        mem_mute = 0;
        do_reset();
        chk("to_err_cleared", timeout_err, 0);
`else
        chk("timeout_err_tied", timeout_err, 0);
`endif

        // Randomized two-client traffic under the reference monitor.
        do_reset();
        sram_mem.delete();
        ref_mem.delete();
        lat_rand = 1;
        tick();
        mon_en = 1;
        fork
            drive_a(40);
            drive_b(40);
        join
        wait_quiet("rand");
        repeat (3) tick();
        mon_en = 0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Absolute time guard.
    initial begin
        #400000;
        $display("FAIL global_timeout: got simulation stall, expected completion");
        $fatal(1, "stall");
    end

endmodule
`default_nettype wire

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Upstream request stage for the 16-bit async SRAM controller. Two clients share one controller: port A is the read-only video/line fetch port, and port B is the CPU read/write port.
- Arbitrates between them and presents exactly one single-cycle read or write request at a time.
- Holds address and write data stable for the whole access, because the controller forwards its address input straight to the SRAM pins.
- Routes the returned read data back to the requesting port.

Parameters:
- MAX_A_BURST, 4: max consecutive port-A grants while B is pending; range 1..15.
- TIMEOUT_CYCLES, 255: cycles in WAIT before abort. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  port A read request; held until a_ack
- a_addr  in  17  port A word address
- a_ack  out  1  one-cycle pulse; A request accepted
- a_rdata  out  16  port A read data
- a_rvalid  out  1  one-cycle pulse; a_rdata valid
- b_req  in  1  port B request; held until b_ack
- b_we  in  1  1 = write, 0 = read
- b_addr  in  17  port B word address
- b_wdata  in  16  port B write data
- b_ack  out  1  one-cycle pulse; B request accepted
- b_rdata  out  16  port B read data
- b_rvalid  out  1  one-cycle pulse; b_rdata valid (reads only)
- b_wdone  out  1  one-cycle pulse; write completed
- mem_read_req  out  1  to controller read_req
- mem_write_req  out  1  to controller write_req
- mem_addr  out  17  to controller addr_in
- mem_wdata  out  16  to controller write_data
- mem_rdata  in  16  from controller read_data
- mem_ready  in  1  from controller ready; one-cycle completion pulse
- busy  out  1  high whenever state is not IDLE
- timeout_err  out  1  sticky error flag (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (async, rst_n=0):
  - state goes to IDLE.
  - All pulse outputs, mem_*_req and busy are 0.
  - mem_addr, mem_wdata, a_rdata and b_rdata are 0.
  - Burst counter is 0 and timeout_err is 0.
  - A reset in mid-access simply aborts it; no response pulse is generated.
- State machine: IDLE -> ISSUE -> WAIT -> IDLE. All outputs are registered.
- IDLE (grant):
  - If only one of a_req/b_req is high, grant that port.
  - If both are high, grant A unless the burst counter equals MAX_A_BURST; in that case grant B.
  - On grant, latch into mem_addr and mem_wdata, and record the owner and the op. Port A is always a read; port B's op is b_we.
  - Go to ISSUE.
- Burst counter:
  - Increments on an A grant made while b_req is high, saturating at MAX_A_BURST.
  - Clears on any B grant, and on an A grant made while b_req is low.
- ISSUE:
  - Assert exactly one of mem_read_req/mem_write_req for exactly one cycle.
  - Assert the owner's ack in the same cycle.
  - Go to WAIT.
- WAIT:
  - mem_addr and mem_wdata stay constant.
  - mem_*_req is 0.
  - On mem_ready=1: capture mem_rdata into the owner's rdata register (reads only) and go to IDLE.
  - In the next cycle (IDLE), pulse the owner's rvalid or b_wdone.
- mem_ready is ignored in IDLE and ISSUE.
- A request dropped before its ack is legal and is simply not granted. Inputs are sampled only in IDLE.
- Each port has at most one outstanding access. A new grant can occur in the same cycle as the previous response pulse.
- Minimum turnaround: request seen in IDLE at cycle 0 -> ack and mem_*_req at cycle 1 -> response pulse one cycle after mem_ready.
- Unselected rdata registers hold their previous value.

Optional Feature:
- Macro: SRAM_ARB_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in WAIT.
  - If it reaches TIMEOUT_CYCLES without mem_ready, return to IDLE and still pulse the owner's rvalid or b_wdone.
  - Read data returned on a timeout is 16'hDEAD.
  - timeout_err is set and stays set until reset.
- When undefined: no counter is built, WAIT waits forever, and timeout_err is constant 0.

Test Plan:
- Single A read, addr 17'h00123, with the memory model returning 16'hBEEF 5 cycles after mem_read_req:
  - a_ack and mem_read_req both high for one cycle, with mem_addr=17'h00123.
  - a_rvalid one cycle after mem_ready, with a_rdata=16'hBEEF.
- B write, addr 17'h1FFFF, data 16'hA5A5:
  - mem_write_req is a single pulse.
  - mem_addr and mem_wdata are stable through WAIT.
  - b_wdone pulses once; b_rvalid stays 0.
- a_req and b_req held continuously, MAX_A_BURST=4:
  - Grant sequence is A,A,A,A,B,A,A,A,A,B.
  - a_rdata does not change on B completions.
- b_req asserted, then deasserted before ack while A is busy: B is never granted and no b_* pulse occurs.
- Reset asserted during WAIT of a B read:
  - All outputs go to 0 immediately.
  - No b_rvalid after release.
  - The next a_req is served normally.
- With SRAM_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, memory never asserts mem_ready:
  - a_rvalid pulses with a_rdata=16'hDEAD.
  - timeout_err is set and stays 1.
